// File: rtl/hazard_detection_unit.sv
// Stall/bubble/flush control for the five-stage RV32 pipeline: load-use, taken branch,
// instruction- and data-memory wait, plus saturating stall and flush counters.
module hazard_detection_unit #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           id_addr1,
   input  logic [4:0]           id_addr2,
   input  logic                 id_use1,
   input  logic                 id_use2,
   input  logic [4:0]           exe_addr,
   input  logic                 exe_mem_read,
   input  logic                 branch_taken,
   input  logic                 imem_busy,
   input  logic                 dmem_busy,
   input  logic                 cnt_clr,
   output logic                 pc_en,
   output logic                 if_id_en,
   output logic                 id_exe_en,
   output logic                 exe_mem_en,
   output logic                 mem_wb_en,
   output logic                 if_id_flush,
   output logic                 id_exe_flush,
   output logic                 state,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
);

   typedef enum logic {RUN = 1'b0, FLUSH_HOLD = 1'b1} state_t;

   state_t state_q;
   state_t state_d;
   logic   load_use;
   logic   stall_inc;
   logic   flush_inc;

   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign load_use = exe_mem_read && (exe_addr != 5'd0) &&
                     ((id_use1 && (id_addr1 == exe_addr)) ||
                      (id_use2 && (id_addr2 == exe_addr)));

   assign state = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (dmem_busy)                state_d = state_q;
      else if (branch_taken)        state_d = imem_busy ? FLUSH_HOLD : RUN;
      else if (state_q == FLUSH_HOLD) state_d = imem_busy ? FLUSH_HOLD : RUN;
      else                          state_d = RUN;
   end

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_exe_en    = 1'b1;
      exe_mem_en   = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_exe_flush = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      if (reset) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_exe_en    = 1'b0;
         exe_mem_en   = 1'b0;
         mem_wb_en    = 1'b0;
         if_id_flush  = 1'b1;
         id_exe_flush = 1'b1;
      end else if (dmem_busy) begin
         // Full freeze keeps a pending branch in EXE so it flushes once the stall clears.
         pc_en      = 1'b0;
         if_id_en   = 1'b0;
         id_exe_en  = 1'b0;
         exe_mem_en = 1'b0;
         mem_wb_en  = 1'b0;
         stall_inc  = 1'b1;
      end else if (branch_taken) begin
         if_id_flush  = 1'b1;
         id_exe_flush = 1'b1;
         flush_inc    = 1'b1;
      end else if (state_q == FLUSH_HOLD) begin
         // PC already holds the target; the in-flight fetch is wrong-path and gets dropped.
         pc_en       = 1'b0;
         if_id_flush = 1'b1;
         stall_inc   = 1'b1;
      end else if (load_use) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_exe_flush = 1'b1;
         stall_inc    = 1'b1;
      end else if (imem_busy) begin
         pc_en       = 1'b0;
         if_id_flush = 1'b1;
         stall_inc   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
         if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
      end
   end

endmodule
